// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32 multicycle control path.
// Holds the FSM state encoding, the opcodes the controller recognises,
// ALUOp / ALUControl codes and the datapath mux-select encodings.
package rv_ctrl_pkg;

    // FSM state encoding (FETCH must be 0; the debug port exposes these codes)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    // Opcodes
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALUOp: what the FSM asks of the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp plus instruction function fields to an
// ALUControl code.
// Ports:
//   alu_op      in  2  ALUOp requested by the FSM
//   funct3      in  3  instruction [14:12]
//   op5         in  1  instruction [5] (distinguishes R-type from I-type)
//   funct7b5    in  1  instruction [30]
//   alu_control out 3  ALU operation
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 selects sub only for R-type; for addi it is an immediate bit
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for an RV32 datapath with a single shared memory port.
// A Moore FSM walks each instruction through fetch/decode/execute/memory/
// writeback, driving datapath enables and mux selects, and stalls on mem_ready.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   mem_ready           shared memory completes the current access
//   Op, funct3, funct7b5 instruction register fields
//   Zero                ALU zero flag (branch condition)
//   PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath selects
//   instr_retired       pulse on the final cycle of each instruction
//   illegal             sticky unknown-opcode flag
//   state               current FSM state (debug)
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned HALT_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ready,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_retired,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] next_state;
    alu_op_t    alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE && !is_known_op(Op)) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTER;
                    OP_ITYPE:     next_state = S_EXECUTEI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = (HALT_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        alu_op        = ALUOP_ADD;
        instr_retired = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                // PC+4 and the IR are captured together when the fetch completes
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                // precompute the branch target from OldPC + ImmExt
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = RES_READDATA;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                MemWrite      = 1'b1;
                instr_retired = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_JAL: begin
                // OldPC + 4 is the link value; PC takes the target computed in DECODE
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_ALUWB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA       = SRCA_RD1;
                alu_op        = ALUOP_SUB;
                PCWrite       = Zero;
                instr_retired = 1'b1;
            end
            default: begin
            end
        endcase
        // no architectural write may escape while reset is held
        if (rst) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            instr_retired = 1'b0;
        end
    end

    always_comb begin
        case (Op)
            OP_LW, OP_ITYPE: ImmSrc = IMM_I;
            OP_SW:           ImmSrc = IMM_S;
            OP_BEQ:          ImmSrc = IMM_B;
            OP_JAL:          ImmSrc = IMM_J;
            default:         ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (Op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table,
// hand-written stall/reset/trap sequences and randomized instruction streams
// compared cycle by cycle against a phase-list reference model.
module tb_multicycle_controller;
    import rv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_retired, illegal;
    logic [3:0] state;

    multicycle_controller #(.HALT_ON_ILLEGAL(1)) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .Op(Op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_retired(instr_retired),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, irw, mw, rw;
        logic [1:0] res, srca, srcb, imm;
        logic [2:0] aluc;
        logic       ret;
    } out_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
    } phase_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         lat;
        logic [2:0] aluc3;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    logic ill_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic known(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    endfunction

    // expected outputs for one cycle, taken from the per-state output table
    function automatic out_t expect_out(input logic [3:0] st, input logic mr, input logic [6:0] op,
                                        input logic [2:0] f3, input logic f7, input logic z,
                                        input logic r);
        out_t o;
        int   aop;
        o = '0;
        aop = 0;
        o.st = st;
        case (op)
            7'b0100011: o.imm = 2'b01;
            7'b1100011: o.imm = 2'b10;
            7'b1101111: o.imm = 2'b11;
            default:    o.imm = 2'b00;
        endcase
        case (st)
            S_FETCH:    begin o.srcb = 2'b10; o.res = 2'b10; o.irw = mr; o.pcw = mr; end
            S_DECODE:   begin o.srca = 2'b01; o.srcb = 2'b01; end
            S_MEMADR:   begin o.srca = 2'b10; o.srcb = 2'b01; end
            S_MEMREAD:  begin o.adr = 1'b1; end
            S_MEMWB:    begin o.res = 2'b01; o.rw = 1'b1; o.ret = 1'b1; end
            S_MEMWRITE: begin o.adr = 1'b1; o.mw = 1'b1; o.ret = mr; end
            S_EXECUTER: begin o.srca = 2'b10; aop = 2; end
            S_EXECUTEI: begin o.srca = 2'b10; o.srcb = 2'b01; aop = 2; end
            S_JAL:      begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1; end
            S_ALUWB:    begin o.rw = 1'b1; o.ret = 1'b1; end
            S_BEQ:      begin o.srca = 2'b10; aop = 1; o.pcw = z; o.ret = 1'b1; end
            default:    begin end
        endcase
        if (aop == 1) o.aluc = 3'b001;
        else if (aop == 2) begin
            case (f3)
                3'b000:  o.aluc = (op[5] && f7) ? 3'b001 : 3'b000;
                3'b010:  o.aluc = 3'b101;
                3'b110:  o.aluc = 3'b011;
                3'b111:  o.aluc = 3'b010;
                default: o.aluc = 3'b000;
            endcase
        end
        if (r) begin o.pcw = 0; o.irw = 0; o.mw = 0; o.rw = 0; o.ret = 0; end
        return o;
    endfunction

    // Runs one instruction from FETCH. wf/wm = stall cycles in fetch / memory phase.
    // rst_idx >= 0 asserts reset in that cycle and abandons the instruction.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic zero, input int wf, input int wm, input int rst_idx,
                             output int lat, output logic [2:0] aluc3,
                             output int mw_cnt, output int commit_cnt, output int rw_cnt);
        phase_t q[$];
        out_t   e, a;
        lat = 0; aluc3 = 3'b111; mw_cnt = 0; commit_cnt = 0; rw_cnt = 0;
        for (int i = 0; i < wf; i++) q.push_back('{S_FETCH, 1'b0});
        q.push_back('{S_FETCH, 1'b1});
        q.push_back('{S_DECODE, 1'($urandom)});
        case (op)
            7'b0000011: begin
                q.push_back('{S_MEMADR, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{S_MEMREAD, 1'b0});
                q.push_back('{S_MEMREAD, 1'b1});
                q.push_back('{S_MEMWB, 1'($urandom)});
            end
            7'b0100011: begin
                q.push_back('{S_MEMADR, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{S_MEMWRITE, 1'b0});
                q.push_back('{S_MEMWRITE, 1'b1});
            end
            7'b0110011: begin q.push_back('{S_EXECUTER, 1'($urandom)}); q.push_back('{S_ALUWB, 1'($urandom)}); end
            7'b0010011: begin q.push_back('{S_EXECUTEI, 1'($urandom)}); q.push_back('{S_ALUWB, 1'($urandom)}); end
            7'b1101111: begin q.push_back('{S_JAL, 1'($urandom)}); q.push_back('{S_ALUWB, 1'($urandom)}); end
            7'b1100011: q.push_back('{S_BEQ, 1'($urandom)});
            default: for (int i = 0; i < 10; i++) q.push_back('{S_TRAP, 1'($urandom)});
        endcase
        Op = op; funct3 = f3; funct7b5 = f7;
        foreach (q[i]) begin
            mem_ready = q[i].mr;
            Zero = (q[i].st == S_BEQ) ? zero : 1'($urandom);
            rst = (i == rst_idx);
            #4;
            e = expect_out(q[i].st, q[i].mr, op, f3, f7, Zero, rst);
            a = '{state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_retired};
            check($sformatf("outputs op=%b cyc=%0d", op, i), 64'(a), 64'(e));
            check($sformatf("illegal op=%b cyc=%0d", op, i), 64'(illegal), 64'(ill_exp));
            if (instr_retired && lat == 0) lat = i + 1;
            if (i == 2) aluc3 = ALUControl;
            if (MemWrite) mw_cnt++;
            if (MemWrite && mem_ready) commit_cnt++;
            if (RegWrite) rw_cnt++;
            if (q[i].st == S_DECODE && !known(op) && !rst) ill_exp = 1'b1;
            if (rst) ill_exp = 1'b0;
            @(posedge clk); #1;
            if (i == rst_idx) break;
        end
    endtask

    vec_t vecs[12];
    int   lat, mwc, cmc, rwc;
    logic [2:0] a3;

    initial begin
        vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000}; // add
        vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001}; // sub
        vecs[2]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101}; // slt
        vecs[3]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011}; // or
        vecs[4]  = '{7'b0110011, 3'b111, 1'b1, 1'b0, 4, 3'b010}; // and
        vecs[5]  = '{7'b0110011, 3'b100, 1'b0, 1'b0, 4, 3'b000}; // xor -> default add
        vecs[6]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000}; // addi, imm bit 30 set
        vecs[7]  = '{7'b0010011, 3'b111, 1'b0, 1'b0, 4, 3'b010}; // andi
        vecs[8]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000}; // lw
        vecs[9]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000}; // sw
        vecs[10] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001}; // beq taken
        vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001}; // beq not taken

        rst = 1'b1; mem_ready = 1'b0; Op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #4;
        check("reset state", 64'(state), 64'(S_FETCH));
        check("reset illegal", 64'(illegal), 64'd0);
        check("reset strobes", 64'({PCWrite, IRWrite, MemWrite, RegWrite, instr_retired}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[k]) begin
            run_instr(vecs[k].op, vecs[k].f3, vecs[k].f7, vecs[k].zero, 0, 0, -1, lat, a3, mwc, cmc, rwc);
            check($sformatf("latency vec%0d", k), 64'(lat), 64'(vecs[k].lat));
            check($sformatf("alucontrol vec%0d", k), 64'(a3), 64'(vecs[k].aluc3));
        end

        // lw with two stall cycles in MEMREAD
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, -1, lat, a3, mwc, cmc, rwc);
        check("lw stall latency", 64'(lat), 64'd7);
        check("lw regwrite pulses", 64'(rwc), 64'd1);

        // sw with three stall cycles in MEMWRITE and one in FETCH
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 3, -1, lat, a3, mwc, cmc, rwc);
        check("sw stall latency", 64'(lat), 64'd8);
        check("sw memwrite cycles", 64'(mwc), 64'd4);
        check("sw commits", 64'(cmc), 64'd1);

        // randomized legal instruction stream
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            int wf, wm, base;
            case ($urandom_range(5))
                0: begin op = 7'b0000011; base = 5; end
                1: begin op = 7'b0100011; base = 4; end
                2: begin op = 7'b0110011; base = 4; end
                3: begin op = 7'b0010011; base = 4; end
                4: begin op = 7'b1101111; base = 4; end
                default: begin op = 7'b1100011; base = 3; end
            endcase
            wf = $urandom_range(2);
            wm = $urandom_range(3);
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), wf, wm, -1, lat, a3, mwc, cmc, rwc);
            check($sformatf("random latency #%0d", n), 64'(lat),
                  64'(base + wf + ((op == 7'b0000011 || op == 7'b0100011) ? wm : 0)));
        end

        // reset asserted in MEMWB: no write strobe, back to FETCH on the edge
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 4, lat, a3, mwc, cmc, rwc);
        check("reset in memwb regwrite", 64'(rwc), 64'd0);
        #4;
        check("state after reset in memwb", 64'(state), 64'(S_FETCH));
        @(posedge clk); #1;
        rst = 1'b0;

        // illegal opcode parks in TRAP
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, -1, lat, a3, mwc, cmc, rwc);
        check("trap retires nothing", 64'(lat), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ill_exp = 1'b0;
        #4;
        check("state after trap reset", 64'(state), 64'(S_FETCH));
        check("illegal after trap reset", 64'(illegal), 64'd0);
        @(posedge clk); #1;
        // FSM sits in FETCH with mem_ready=1 -> DECODE; realign by reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, -1, lat, a3, mwc, cmc, rwc);
        check("add after trap", 64'(lat), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
